fifo_write_arbiter: RTL



---
 rtl/fifo_write_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the asyn_fifo write port between NUM_REQ write-domain producers.
// Define FIFO_ARB_BURST_EN to allow up to BURST_LEN beats per grant; otherwise each grant is one beat.
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned BURST_LEN  = 4,
  localparam int unsigned IdW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic [NUM_REQ-1:0]              REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_DATA,
  output logic [NUM_REQ-1:0]              REQ_READY,
  input  logic                            FULL,
  output logic                            W_EN,
  output logic [DATA_WIDTH-1:0]           DATA_IN,
  output logic [IdW-1:0]                  GRANT_ID,
  output logic                            BUSY,
  output logic [15:0]                     BEAT_CNT
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 16) begin : gen_bad_cfg
    $error("fifo_write_arbiter: NUM_REQ must be 2..8 and BURST_LEN 1..16");
  end

  typedef enum logic {StIdle, StGrant} state_e;

  state_e          state_q;
  logic [IdW-1:0]  grant_id_q;
  logic [IdW-1:0]  last_q;
  logic [15:0]     beat_cnt_q;

  logic                  busy;
  logic                  gnt_valid;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  beat;
  logic                  last_beat;
  logic                  early_exit;

  logic                  win_found;
  logic [IdW-1:0]        win_id;
  logic [IdW-1:0]        cand;

  assign busy       = (state_q == StGrant);
  assign gnt_valid  = REQ_VALID[grant_id_q];
  assign gnt_data   = REQ_DATA[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
  assign beat       = busy & gnt_valid & ~FULL;
  // FULL masks the early-release check so a stalled grant is never dropped.
  assign early_exit = busy & ~gnt_valid & ~FULL;

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [CntW-1:0] burst_cnt_q;

  assign last_beat = (burst_cnt_q == CntW'(BURST_LEN - 1));
`else
  assign last_beat = 1'b1;
`endif

  // Search starts one past the previous grant holder.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IdW'((32'(last_q) + i) % NUM_REQ);
      if (!win_found && REQ_VALID[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    W_EN      = 1'b0;
    REQ_READY = '0;
    DATA_IN   = '0;
    if (busy) begin
      W_EN                  = beat;
      REQ_READY[grant_id_q] = ~FULL;
      DATA_IN               = gnt_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      grant_id_q <= '0;
      last_q     <= IdW'(NUM_REQ - 1);
      beat_cnt_q <= '0;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      if (beat) begin
        beat_cnt_q <= beat_cnt_q + 16'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            grant_id_q <= win_id;
            state_q    <= StGrant;
`ifdef FIFO_ARB_BURST_EN
            burst_cnt_q <= '0;
`endif
          end
        end
        StGrant: begin
          if ((beat && last_beat) || early_exit) begin
            state_q <= StIdle;
            last_q  <= grant_id_q;
          end
`ifdef FIFO_ARB_BURST_EN
          if (beat) begin
            burst_cnt_q <= burst_cnt_q + CntW'(1);
          end
`endif
        end
      endcase
    end
  end

  assign GRANT_ID = grant_id_q;
  assign BUSY     = busy;
  assign BEAT_CNT = beat_cnt_q;

endmodule
